vliw_bundle_packer: RTL
=======================

// Module: vliw_bundle_packer
// PURPOSE
//  Issue-side producer for the fetch stage. Takes single-slot ops over a valid/ready stream.
//  Packs up to three independent ops into one 64-bit VLIW word plus a 192-bit data bundle,
//  in the field layout the fetch stage decodes. Closes a bundle early on an intra-bundle
//  hazard, on in_last, or on idle timeout.
// PARAMETERS
//  TIMEOUT  8  consecutive idle cycles before a partial bundle is force-closed (>=1)
//  HAZARD   1  1: close bundle on RAW/WAW against ops already packed; 0: pack blindly
// PORTS
//  clock     in   1   single clock, rising edge
//  reset     in   1   asynchronous, active-low; clears all state
//  flush     in   1   sync; discard partial bundle and output register
//  in_valid  in   1   op offered
//  in_ready  out  1   op accepted when in_valid&in_ready
//  in_op     in   4   opcode (0000 nop ... 0100 load ... 1111 bshiftright)
//  in_src1   in   4   source register 1
//  in_src2   in   4   source register 2
//  in_dest   in   4   destination register
//  in_data   in   64  immediate; used only when in_op==0100 (load)
//  in_last   in   1   close bundle after this op
//  out_valid out  1   word/data valid
//  out_ready in   1   consumer takes bundle when out_valid&out_ready
//  word      out  64  packed VLIW word
//  data      out  192 per-slot data lanes
//  out_slots out  2   number of occupied slots in word (1..3)
// BEHAVIOUR
//  Slot k=1,2,3 at base b=60-20k: op [b+18:b+15], src1 [b+13:b+10], src2 [b+8:b+5], dest [b+3:b].
//  Slot1 op is [58:55]; slot3 dest is [3:0]. All other word bits are 0.
//  Empty slots: op=0000, regs=0000. Data lanes: slot1 [191:128], slot2 [127:64], slot3 [63:0].
//  A lane holds in_data only for a load op; otherwise it is 0.
//  State: accumulator (slots, cnt 0..3), idle counter, pending_close flag, 1-entry output reg.
//  Slots fill in order 1,2,3. An accepted nop is consumed and occupies no slot.
//    An accepted nop with in_last still closes a non-empty bundle.
//  Hazard (HAZARD=1, cnt>0, op not nop): in_src1, in_src2 or in_dest equals the dest of any packed op.
//  out_free = !out_valid | out_ready.
//  in_ready = !flush & (out_free | !close_now), where close_now is any of:
//    hazard; op fills slot 3; in_last; timeout; pending_close.
//  Accept without hazard: op goes into slot cnt+1.
//    If cnt becomes 3 or in_last is set, the bundle moves to the output reg this edge.
//  Accept with hazard: old bundle moves to the output reg; the op becomes slot1 of a new bundle.
//    If in_last was also set, pending_close is set so the new bundle closes on the next out_free cycle.
//  Latency: a bundle closed at edge N has out_valid=1 at cycle N+1.
//    Zero bubble when out_ready stays high.
//  Idle counter: cleared on accept or when cnt==0; increments each cycle with cnt>0 and no accept.
//    At TIMEOUT the bundle closes when out_free; otherwise it holds at TIMEOUT.
//  Output reg: word, data and out_slots are stable while out_valid & !out_ready.
//    Reload and drain in the same cycle is allowed.
//  flush=1: cnt, idle counter, pending_close, out_valid <=0; accumulator zeroed; no accept that cycle.
//    flush takes priority over every close condition.
//  reset=0 (async, any time): word=0, data=0, out_slots=0, out_valid=0; accumulator, counters, flags 0.
//    in_ready=0 while reset is low and 1 on the first cycle after release.
//  A partial bundle in flight at reset or flush is lost, never emitted.
// TESTING
//  T1 Three independent ops, out_ready=1: add(1,2->3), sub(4,5->6), mul(7,8->9) on consecutive cycles.
//     -> one cycle after the 3rd accept: out_valid=1, out_slots=3.
//     -> word[58:55]=1, [53:50]=1, [48:45]=2, [43:40]=3; [38:35]=2, [23:20]=6; [18:15]=3, [3:0]=9; data=0.
//  T2 RAW: add(1,2->3) then sub(3,4->5).
//     -> first word has out_slots=1, slot1=add and slots 2/3 all zero.
//     -> sub becomes slot1 of the next bundle; no cycle lost on in_ready.
//  T3 Timeout (TIMEOUT=8): accept one add at cycle 0, then idle.
//     -> out_valid rises at cycle 9 with out_slots=1; no earlier emission.
//  T4 Backpressure: out_ready=0, output occupied, third op offered.
//     -> in_ready=0 and word/data unchanged for 5 cycles.
//     -> when out_ready=1: old bundle drains, the op is accepted that same cycle, new bundle valid the next cycle.
//  T5 Load lane: nop, add(1,1->2), then load(0,0->4) with in_data=64'hDEADBEEF_CAFEF00D and in_last.
//     -> out_slots=2, word[38:35]=0100, data[127:64]=64'hDEADBEEF_CAFEF00D, other lanes 0.
//  T6 Disruption: two ops packed, then flush for 1 cycle -> no bundle emitted.
//     Repeat with reset pulsed low mid-cycle -> out_valid, word and data go to 0 immediately (asynchronously).

Source files
------------

// File: rtl/vliw_bundle_packer.sv
// vliw_bundle_packer: packs up to three single-slot ops into one 64-bit VLIW word plus a
// 192-bit per-slot data bundle. Bundles close early on a RAW/WAW hazard, on in_last,
// or after TIMEOUT idle cycles, and are handed to the fetch stage through a 1-entry
// output register.
module vliw_bundle_packer #(
    parameter int unsigned TIMEOUT = 8,
    parameter bit          HAZARD  = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_flush,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [3:0]     i_in_op,
    input  logic [3:0]     i_in_src1,
    input  logic [3:0]     i_in_src2,
    input  logic [3:0]     i_in_dest,
    input  logic [63:0]    i_in_data,
    input  logic           i_in_last,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [63:0]    o_word,
    output logic [191:0]   o_data,
    output logic [1:0]     o_out_slots
);

    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT);
    localparam logic [IdleW-1:0] IdleDue = IdleW'(TIMEOUT - 1);
    localparam logic [3:0] OpNop  = 4'b0000;
    localparam logic [3:0] OpLoad = 4'b0100;

    // Index 0 is slot 1 (the first op packed), index 2 is slot 3.
    logic [2:0][3:0]  r_op, r_src1, r_src2, r_dest;
    logic [2:0][63:0] r_lane;
    logic [1:0]       r_cnt;
    logic [IdleW-1:0] r_idle;
    logic             r_pend;
    logic             r_out_valid;
    logic [63:0]      r_word;
    logic [191:0]     r_data;
    logic [1:0]       r_slots;

    logic [2:0][3:0]  w_ins_op, w_ins_src1, w_ins_src2, w_ins_dest;
    logic [2:0][63:0] w_ins_lane;
    logic [2:0][3:0]  w_op_nxt, w_src1_nxt, w_src2_nxt, w_dest_nxt;
    logic [2:0][63:0] w_lane_nxt;
    logic [1:0]       w_cnt_nxt;
    logic [IdleW-1:0] w_idle_nxt;
    logic             w_pend_nxt;
    logic             w_load_out;
    logic [63:0]      w_word_nxt;
    logic [191:0]     w_data_nxt;
    logic [1:0]       w_slots_nxt;

    logic w_is_nop, w_is_load, w_match, w_hazard, w_fill3;
    logic w_timeout, w_idle_due, w_force, w_close_now, w_out_free, w_accept;
    logic [63:0] w_in_lane;

    function automatic logic [63:0] pack_word(input logic [2:0][3:0] op,
                                              input logic [2:0][3:0] src1,
                                              input logic [2:0][3:0] src2,
                                              input logic [2:0][3:0] dest);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 3; k++) begin
            w[58-20*k -: 4] = op[k];
            w[53-20*k -: 4] = src1[k];
            w[48-20*k -: 4] = src2[k];
            w[43-20*k -: 4] = dest[k];
        end
        return w;
    endfunction

    function automatic logic [191:0] pack_data(input logic [2:0][63:0] lane);
        return {lane[0], lane[1], lane[2]};
    endfunction

    assign w_is_nop   = (i_in_op == OpNop);
    assign w_is_load  = (i_in_op == OpLoad);
    assign w_in_lane  = w_is_load ? i_in_data : 64'd0;
    assign w_out_free = !r_out_valid || i_out_ready;

    // Compare the offered op's registers against the dest of every op already packed.
    always_comb begin
        w_match = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k < int'(r_cnt) && (i_in_src1 == r_dest[k] || i_in_src2 == r_dest[k] ||
                                    i_in_dest == r_dest[k])) begin
                w_match = 1'b1;
            end
        end
    end

    assign w_hazard   = HAZARD && (r_cnt != 2'd0) && !w_is_nop && w_match;
    assign w_fill3    = !w_is_nop && (r_cnt == 2'd2);
    // w_timeout: already saturated and waiting for room; w_idle_due: this idle cycle is the last.
    assign w_timeout  = (r_cnt != 2'd0) && (r_idle == IdleMax);
    assign w_idle_due = (r_cnt != 2'd0) && (r_idle >= IdleDue);
    assign w_force    = (r_cnt != 2'd0) && (w_timeout || r_pend);

    assign w_close_now = (i_in_valid && (w_hazard || w_fill3 || i_in_last)) || w_force;
    assign o_in_ready  = i_rst_n && !i_flush && (w_out_free || !w_close_now);
    assign w_accept    = i_in_valid && o_in_ready;

    // Accumulator with the offered op dropped into the next free slot.
    always_comb begin
        w_ins_op   = r_op;
        w_ins_src1 = r_src1;
        w_ins_src2 = r_src2;
        w_ins_dest = r_dest;
        w_ins_lane = r_lane;
        for (int k = 0; k < 3; k++) begin
            if (k == int'(r_cnt)) begin
                w_ins_op[k]   = i_in_op;
                w_ins_src1[k] = i_in_src1;
                w_ins_src2[k] = i_in_src2;
                w_ins_dest[k] = i_in_dest;
                w_ins_lane[k] = w_in_lane;
            end
        end
    end

    // Next accumulator state and the bundle (if any) handed to the output register.
    always_comb begin
        w_op_nxt    = r_op;
        w_src1_nxt  = r_src1;
        w_src2_nxt  = r_src2;
        w_dest_nxt  = r_dest;
        w_lane_nxt  = r_lane;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_load_out  = 1'b0;
        w_word_nxt  = '0;
        w_data_nxt  = '0;
        w_slots_nxt = '0;
        if (w_accept) begin
            if (w_is_nop) begin
                // A nop takes no slot but still honours in_last / a forced close.
                if (r_cnt != 2'd0 && (i_in_last || w_force)) begin
                    w_load_out  = 1'b1;
                    w_word_nxt  = pack_word(r_op, r_src1, r_src2, r_dest);
                    w_data_nxt  = pack_data(r_lane);
                    w_slots_nxt = r_cnt;
                    w_op_nxt    = '0;
                    w_src1_nxt  = '0;
                    w_src2_nxt  = '0;
                    w_dest_nxt  = '0;
                    w_lane_nxt  = '0;
                    w_cnt_nxt   = 2'd0;
                    w_pend_nxt  = 1'b0;
                end
            end else if (w_hazard || w_force) begin
                // Old bundle leaves; the op opens a new one. A second close this edge
                // has nowhere to go, so in_last is deferred via pending_close.
                w_load_out    = 1'b1;
                w_word_nxt    = pack_word(r_op, r_src1, r_src2, r_dest);
                w_data_nxt    = pack_data(r_lane);
                w_slots_nxt   = r_cnt;
                w_op_nxt      = '0;
                w_src1_nxt    = '0;
                w_src2_nxt    = '0;
                w_dest_nxt    = '0;
                w_lane_nxt    = '0;
                w_op_nxt[0]   = i_in_op;
                w_src1_nxt[0] = i_in_src1;
                w_src2_nxt[0] = i_in_src2;
                w_dest_nxt[0] = i_in_dest;
                w_lane_nxt[0] = w_in_lane;
                w_cnt_nxt     = 2'd1;
                w_pend_nxt    = i_in_last;
            end else if (r_cnt == 2'd2 || i_in_last) begin
                w_load_out  = 1'b1;
                w_word_nxt  = pack_word(w_ins_op, w_ins_src1, w_ins_src2, w_ins_dest);
                w_data_nxt  = pack_data(w_ins_lane);
                w_slots_nxt = r_cnt + 2'd1;
                w_op_nxt    = '0;
                w_src1_nxt  = '0;
                w_src2_nxt  = '0;
                w_dest_nxt  = '0;
                w_lane_nxt  = '0;
                w_cnt_nxt   = 2'd0;
                w_pend_nxt  = 1'b0;
            end else begin
                w_op_nxt   = w_ins_op;
                w_src1_nxt = w_ins_src1;
                w_src2_nxt = w_ins_src2;
                w_dest_nxt = w_ins_dest;
                w_lane_nxt = w_ins_lane;
                w_cnt_nxt  = r_cnt + 2'd1;
            end
        end else if ((w_force || w_idle_due) && w_out_free) begin
            w_load_out  = 1'b1;
            w_word_nxt  = pack_word(r_op, r_src1, r_src2, r_dest);
            w_data_nxt  = pack_data(r_lane);
            w_slots_nxt = r_cnt;
            w_op_nxt    = '0;
            w_src1_nxt  = '0;
            w_src2_nxt  = '0;
            w_dest_nxt  = '0;
            w_lane_nxt  = '0;
            w_cnt_nxt   = 2'd0;
            w_pend_nxt  = 1'b0;
        end
    end

    // Idle counter saturates at TIMEOUT while the output register is blocked.
    always_comb begin
        w_idle_nxt = r_idle;
        if (w_accept || r_cnt == 2'd0 || w_cnt_nxt == 2'd0) begin
            w_idle_nxt = '0;
        end else if (r_idle != IdleMax) begin
            w_idle_nxt = r_idle + 1'b1;
        end
    end

    // Accumulator, idle counter and pending-close state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op   <= '0;
            r_src1 <= '0;
            r_src2 <= '0;
            r_dest <= '0;
            r_lane <= '0;
            r_cnt  <= 2'd0;
            r_idle <= '0;
            r_pend <= 1'b0;
        end else if (i_flush) begin
            r_op   <= '0;
            r_src1 <= '0;
            r_src2 <= '0;
            r_dest <= '0;
            r_lane <= '0;
            r_cnt  <= 2'd0;
            r_idle <= '0;
            r_pend <= 1'b0;
        end else begin
            r_op   <= w_op_nxt;
            r_src1 <= w_src1_nxt;
            r_src2 <= w_src2_nxt;
            r_dest <= w_dest_nxt;
            r_lane <= w_lane_nxt;
            r_cnt  <= w_cnt_nxt;
            r_idle <= w_idle_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    // One-entry output register; reload and drain may coincide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_word      <= '0;
            r_data      <= '0;
            r_slots     <= 2'd0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_word      <= '0;
            r_data      <= '0;
            r_slots     <= 2'd0;
        end else if (w_load_out) begin
            r_out_valid <= 1'b1;
            r_word      <= w_word_nxt;
            r_data      <= w_data_nxt;
            r_slots     <= w_slots_nxt;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_word      = r_word;
    assign o_data      = r_data;
    assign o_out_slots = r_slots;

endmodule
